// File: rtl/wifi_phy_pkg.sv
// Shared Wi-Fi PHY receive constants: FSM state encodings and OFDM symbol geometry.
package wifi_phy_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CP   = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int WIFI_NFFT     = 64;
    localparam int WIFI_CP_LONG  = 16;
    localparam int WIFI_CP_SHORT = 8;

endpackage

// File: rtl/wifi_cp_remover_if.sv
// Sample stream, burst control and FIFO write port of the cyclic-prefix remover.
interface wifi_cp_remover_if #(
    parameter int DATA  = 12,
    parameter int SYM_W = 8
);
    logic             valid_in;
    logic [DATA-1:0]  data_in;
    logic             sync_start;
    logic [SYM_W-1:0] n_sym;
    logic             gi_short;
    logic             abort;
    logic             fifo_ready;
    logic             we;
    logic [DATA-1:0]  data_out;
    logic             sym_start;
    logic             burst_done;
    logic             busy;
    logic             drop_err;

    modport master (
        output valid_in, data_in, sync_start, n_sym, gi_short, abort, fifo_ready,
        input  we, data_out, sym_start, burst_done, busy, drop_err
    );

    modport slave (
        input  valid_in, data_in, sync_start, n_sym, gi_short, abort, fifo_ready,
        output we, data_out, sym_start, burst_done, busy, drop_err
    );
endinterface

// File: rtl/wifi_cp_rm_ctr.sv
// Sample and symbol counters of the CP remover, with terminal-count flags for the FSM.
module wifi_cp_rm_ctr
    import wifi_phy_pkg::*;
#(
    parameter int NFFT  = WIFI_NFFT,
    parameter int CNT_W = 7,
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cnt_load,
    input  logic             i_cnt_load_one,
    input  logic             i_cnt_inc,
    input  logic             i_sym_clr,
    input  logic             i_sym_inc,
    input  logic [CNT_W-1:0] i_cp_len,
    input  logic [SYM_W-1:0] i_n_sym,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cp_last,
    output logic             o_data_last,
    output logic             o_sym_last
);

    logic [CNT_W-1:0] r_cnt;
    logic [SYM_W-1:0] r_sym_cnt;

    // Load wins over increment so a phase change never skips a sample position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_sym_cnt <= '0;
        end else begin
            if (i_cnt_load)
                r_cnt <= i_cnt_load_one ? CNT_W'(1) : '0;
            else if (i_cnt_inc)
                r_cnt <= r_cnt + CNT_W'(1);

            if (i_sym_clr)
                r_sym_cnt <= '0;
            else if (i_sym_inc)
                r_sym_cnt <= r_sym_cnt + SYM_W'(1);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_cp_last   = (r_cnt == (i_cp_len - CNT_W'(1)));
    assign o_data_last = (r_cnt == CNT_W'(NFFT - 1));
    // n_sym of zero means an endless burst, so the symbol counter just wraps.
    assign o_sym_last  = (i_n_sym != '0) && (r_sym_cnt == (i_n_sym - SYM_W'(1)));

endmodule

// File: rtl/wifi_cp_remover.sv
// Receive guard-interval stripper: drops the CP of each OFDM symbol and writes the NFFT useful
// samples to the FFT FIFO, dropping whole symbols when the FIFO is not ready. Option: WIFI_SHORT_GI_EN.
module wifi_cp_remover
    import wifi_phy_pkg::*;
#(
    parameter int DATA     = 12,
    parameter int NFFT     = WIFI_NFFT,
    parameter int CP_LEN   = WIFI_CP_LONG,
    parameter int CP_SHORT = WIFI_CP_SHORT,
    parameter int CNT_W    = 7,
    parameter int SYM_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    wifi_cp_remover_if.slave   bus
);

    logic [1:0]       r_state;
    logic             r_keep;
    logic [SYM_W-1:0] r_n_sym;
    logic             r_we;
    logic [DATA-1:0]  r_data_out;
    logic             r_sym_start;
    logic             r_burst_done;
    logic             r_drop_err;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cp_len;
    logic             w_cp_last;
    logic             w_data_last;
    logic             w_sym_last;
    logic             w_start;
    logic             w_cp_done;
    logic             w_sym_done;
    logic             w_cnt_load;
    logic             w_cnt_inc;

    // Abort gates every transition so it always beats a coincident sync_start.
    assign w_start    = (r_state == ST_IDLE) && bus.valid_in && bus.sync_start && !bus.abort;
    assign w_cp_done  = (r_state == ST_CP)   && bus.valid_in && w_cp_last   && !bus.abort;
    assign w_sym_done = (r_state == ST_DATA) && bus.valid_in && w_data_last && !bus.abort;
    assign w_cnt_load = bus.abort || w_start || w_cp_done || w_sym_done;
    assign w_cnt_inc  = bus.valid_in && !bus.abort && (r_state != ST_IDLE);

`ifdef WIFI_SHORT_GI_EN
    logic r_gi_short;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_gi_short <= 1'b0;
        else if (w_start)
            r_gi_short <= bus.gi_short;
    end

    assign w_cp_len = r_gi_short ? CNT_W'(CP_SHORT) : CNT_W'(CP_LEN);
`else
    assign w_cp_len = CNT_W'(CP_LEN);
`endif

    wifi_cp_rm_ctr #(
        .NFFT  (NFFT),
        .CNT_W (CNT_W),
        .SYM_W (SYM_W)
    ) u_ctr (
        .clk            (clk),
        .reset          (reset),
        .i_cnt_load     (w_cnt_load),
        .i_cnt_load_one (w_start),
        .i_cnt_inc      (w_cnt_inc),
        .i_sym_clr      (w_start),
        .i_sym_inc      (w_sym_done),
        .i_cp_len       (w_cp_len),
        .i_n_sym        (r_n_sym),
        .o_cnt          (w_cnt),
        .o_cp_last      (w_cp_last),
        .o_data_last    (w_data_last),
        .o_sym_last     (w_sym_last)
    );

    // The keep decision is frozen at CP->DATA so a symbol is written entirely or not at all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_keep       <= 1'b0;
            r_n_sym      <= '0;
            r_we         <= 1'b0;
            r_data_out   <= '0;
            r_sym_start  <= 1'b0;
            r_burst_done <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_sym_start  <= 1'b0;
            r_burst_done <= 1'b0;
            if (bus.abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state    <= ST_CP;
                            r_n_sym    <= bus.n_sym;
                            r_drop_err <= 1'b0;
                        end
                    end
                    ST_CP: begin
                        if (w_cp_done) begin
                            r_state <= ST_DATA;
                            r_keep  <= bus.fifo_ready;
                        end
                    end
                    ST_DATA: begin
                        if (bus.valid_in) begin
                            if (r_keep) begin
                                r_we        <= 1'b1;
                                r_data_out  <= bus.data_in;
                                r_sym_start <= (w_cnt == '0);
                            end else begin
                                r_drop_err  <= 1'b1;
                            end
                            if (w_data_last) begin
                                if (w_sym_last) begin
                                    r_state      <= ST_IDLE;
                                    r_burst_done <= 1'b1;
                                end else begin
                                    r_state      <= ST_CP;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.we         = r_we;
    assign bus.data_out   = r_data_out;
    assign bus.sym_start  = r_sym_start;
    assign bus.burst_done = r_burst_done;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.drop_err   = r_drop_err;

endmodule
